// File: rtl/add3_result_fifo_acc.sv
// add3_result_fifo_acc
// Captures the 6-bit result word and select bit of the upstream 3-bit add/select
// stage into a small FIFO with a valid/ready handshake on both sides, and keeps a
// saturating running sum of the sum field of every word popped in add mode.
// Optional feature: define ADD3_RESULT_FIFO_PARITY_EN to store an even-parity
// bit per entry and present it on out_par; otherwise out_par is tied to 0.
module add3_result_fifo_acc #(
    parameter int DEPTH = 4,   // power of two, 2..16
    parameter int ACC_W = 8    // >= 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic                     in_sel,
    input  logic [5:0]               in_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_sel,
    output logic [5:0]               out_data,
    output logic                     out_par,
    input  logic                     clr_acc,
    output logic [ACC_W-1:0]         acc,
    output logic                     acc_sat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    logic [5:0]       r_data_mem [DEPTH];
    logic             r_sel_mem  [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_sat;

    logic             w_push;
    logic             w_pop;
    logic             w_add_pop;
    logic [ACC_W-1:0] w_acc_base;
    logic [ACC_W:0]   w_acc_sum;

    // Handshake: readiness depends on occupancy only, so a full FIFO never
    // accepts a word even when the head is being taken in the same cycle.
    assign in_rdy  = (r_count != FULL_CNT);
    assign out_vld = (r_count != '0);
    assign w_push  = in_vld & in_rdy;
    assign w_pop   = out_vld & out_rdy;

    assign out_sel  = r_sel_mem[r_rd_ptr];
    assign out_data = r_data_mem[r_rd_ptr];
    assign count    = r_count;
    assign acc      = r_acc;
    assign acc_sat  = r_acc_sat;

    // Clear is applied before the add, so a clear plus add-mode pop loads the sum field.
    assign w_add_pop  = w_pop & ~out_sel;
    assign w_acc_base = clr_acc ? '0 : r_acc;
    assign w_acc_sum  = {1'b0, w_acc_base} + {{(ACC_W-2){1'b0}}, out_data[5:3]};

    // Entry storage write on an accepted push.
    // NOTE: storage has no reset; an entry is only ever read after it was written,
    // and leaving it unreset lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_data_mem[r_wr_ptr] <= in_data;
            r_sel_mem[r_wr_ptr]  <= in_sel;
        end
    end

`ifdef ADD3_RESULT_FIFO_PARITY_EN
    logic r_par_mem [DEPTH];

    // Parity bit captured alongside each entry.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_par_mem[r_wr_ptr] <= ^in_data;
        end
    end

    assign out_par = r_par_mem[r_rd_ptr];
`else
    assign out_par = 1'b0;
`endif

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating accumulator of the sum field over add-mode pops, with sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (w_add_pop) begin
            if (w_acc_sum[ACC_W]) begin
                r_acc     <= ACC_MAX;
                r_acc_sat <= 1'b1;
            end else begin
                r_acc     <= w_acc_sum[ACC_W-1:0];
                r_acc_sat <= clr_acc ? 1'b0 : r_acc_sat;
            end
        end else if (clr_acc) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add3_result_fifo_acc.sv
// Testbench for add3_result_fifo_acc: directed scenarios plus randomized traffic,
// checked by a scoreboard queue and a saturating-sum reference model.
module tb_add3_result_fifo_acc;

    localparam int DEPTH   = 4;
    localparam int ACC_W   = 4;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic                   clk;
    logic                   rst;
    logic                   in_vld;
    logic                   in_rdy;
    logic                   in_sel;
    logic [5:0]             in_data;
    logic                   out_vld;
    logic                   out_rdy;
    logic                   out_sel;
    logic [5:0]             out_data;
    logic                   out_par;
    logic                   clr_acc;
    logic [ACC_W-1:0]       acc;
    logic                   acc_sat;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sel;
        logic [5:0] data;
        logic       par;
    } entry_t;

    entry_t exp_q[$];
    int     m_acc = 0;
    logic   m_sat = 1'b0;

    add3_result_fifo_acc #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_sel  (out_sel),
        .out_data (out_data),
        .out_par  (out_par),
        .clr_acc  (clr_acc),
        .acc      (acc),
        .acc_sat  (acc_sat),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_parity(input logic [5:0] d);
`ifdef ADD3_RESULT_FIFO_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor / scoreboard: samples on the falling edge, compares the DUT against
    // the model, then advances the model by what the next rising edge will do.
    always @(negedge clk) begin
        entry_t e;
        bit     do_pop;
        bit     do_push;
        int     t;
        if (rst) begin
            exp_q.delete();
            m_acc = 0;
            m_sat = 1'b0;
        end else begin
            check("count",   32'(count),   32'(exp_q.size()));
            check("in_rdy",  32'(in_rdy),  32'(exp_q.size() != DEPTH));
            check("out_vld", 32'(out_vld), 32'(exp_q.size() != 0));
            check("acc",     32'(acc),     32'(m_acc));
            check("acc_sat", 32'(acc_sat), 32'(m_sat));
            if (exp_q.size() > 0) begin
                check("head_data", 32'(out_data), 32'(exp_q[0].data));
                check("head_sel",  32'(out_sel),  32'(exp_q[0].sel));
                check("head_par",  32'(out_par),  32'(exp_q[0].par));
            end
            do_pop  = out_rdy && (exp_q.size() > 0);
            do_push = in_vld && (exp_q.size() != DEPTH);
            if (clr_acc) begin
                m_acc = 0;
                m_sat = 1'b0;
            end
            if (do_pop) begin
                e = exp_q.pop_front();
                if (!e.sel) begin
                    t = m_acc + int'(e.data[5:3]);
                    if (t > ACC_MAX) begin
                        m_acc = ACC_MAX;
                        m_sat = 1'b1;
                    end else begin
                        m_acc = t;
                    end
                end
            end
            if (do_push) begin
                e.sel  = in_sel;
                e.data = in_data;
                e.par  = exp_parity(in_data);
                exp_q.push_back(e);
            end
        end
    end

    // One clock of stimulus; returns #1 after the rising edge.
    task automatic step(input logic vld, input logic sel, input logic [5:0] data,
                        input logic ordy, input logic clr, input logic r);
        in_vld  = vld;
        in_sel  = sel;
        in_data = data;
        out_rdy = ordy;
        clr_acc = clr;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [5:0] data);
        step(1'b1, sel, data, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic clr);
        step(1'b0, 1'b0, 6'd0, 1'b1, clr, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] words [4];
        words[0] = 6'o12; words[1] = 6'o23; words[2] = 6'o34; words[3] = 6'o45;

        in_vld = 0; in_sel = 0; in_data = 0; out_rdy = 0; clr_acc = 0; rst = 1;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        idle();
        check("reset_count",   32'(count),   32'd0);
        check("reset_out_vld", 32'(out_vld), 32'd0);
        check("reset_in_rdy",  32'(in_rdy),  32'd1);
        check("reset_acc",     32'(acc),     32'd0);
        check("reset_acc_sat", 32'(acc_sat), 32'd0);

        // Fill, then a fifth push that must be refused.
        for (int i = 0; i < 4; i++) push(1'b0, words[i]);
        check("t1_count",  32'(count),    32'd4);
        check("t1_in_rdy", 32'(in_rdy),   32'd0);
        check("t1_head",   32'(out_data), 32'(6'o12));
        push(1'b0, 6'o77);
        check("t1_full_count", 32'(count),    32'd4);
        check("t1_full_head",  32'(out_data), 32'(6'o12));

        // Drain in order; acc accumulates 1+2+3+4.
        for (int i = 0; i < 4; i++) begin
            check("t2_order", 32'(out_data), 32'(words[i]));
            pop(1'b0);
        end
        check("t2_acc",     32'(acc),     32'd10);
        check("t2_out_vld", 32'(out_vld), 32'd0);

        // Steady-state push+pop at count=2 across pointer wrap.
        push(1'(($urandom)), 6'($urandom));
        push(1'(($urandom)), 6'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom), 6'($urandom), 1'b1, 1'b0, 1'b0);
            check("t3_count", 32'(count), 32'd2);
        end
        for (int i = 0; i < 2; i++) pop(1'b0);

        // Saturation: 7, 14, 15 (sticky), then pass-through pop leaves 15.
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        push(1'b0, {3'd7, 3'd1});
        push(1'b0, {3'd7, 3'd2});
        push(1'b0, {3'd7, 3'd3});
        push(1'b1, {3'd6, 3'd4});
        pop(1'b0); check("t4_acc_a", 32'(acc), 32'd7);
        pop(1'b0); check("t4_acc_b", 32'(acc), 32'd14);
        check("t4_sat_b", 32'(acc_sat), 32'd0);
        pop(1'b0); check("t4_acc_c", 32'(acc), 32'd15);
        check("t4_sat_c", 32'(acc_sat), 32'd1);
        pop(1'b0); check("t4_acc_d", 32'(acc), 32'd15);
        check("t4_sat_d", 32'(acc_sat), 32'd1);

        // Clear then add in the same cycle.
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        push(1'b0, {3'd4, 3'd0});
        push(1'b0, {3'd5, 3'd0});
        push(1'b0, {3'd5, 3'd7});
        pop(1'b0); pop(1'b0);
        check("t5_acc_pre", 32'(acc), 32'd9);
        pop(1'b1);
        check("t5_acc", 32'(acc), 32'd5);
        check("t5_sat", 32'(acc_sat), 32'd0);

        // Reset with words in flight, then parity of a fresh head.
        push(1'b0, 6'o11); push(1'b1, 6'o22); push(1'b0, 6'o33);
        check("t6_count_pre", 32'(count), 32'd3);
        step(1'b1, 1'b0, 6'o44, 1'b1, 1'b0, 1'b1);
        check("t6_count", 32'(count), 32'd0);
        check("t6_acc",   32'(acc),   32'd0);
        push(1'b0, 6'b000111);
        check("t6_out_vld", 32'(out_vld),  32'd1);
        check("t6_head",    32'(out_data), 32'(6'b000111));
        check("t6_par",     32'(out_par),  32'(exp_parity(6'b000111)));
        pop(1'b0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'(($urandom % 4) != 0), 1'($urandom), 6'($urandom),
                 1'(($urandom % 3) != 0), 1'(($urandom % 50) == 0),
                 1'(($urandom % 400) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) pop(1'b0);
        check("drain_count", 32'(count), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
